// File: rtl/proc_buf_pkg.sv
// Shared constants and types for the proc block and its output byte buffer.
package proc_buf_pkg;

  localparam int unsigned PROC_BYTE_W    = 8;
  localparam int unsigned PROC_WORD_W    = 32;
  localparam int unsigned PROC_BUF_DEPTH = 256;
  localparam int unsigned PROC_BUF_AW    = 8;

  typedef logic [PROC_BYTE_W-1:0] byte_t;

  // Per-cycle buffer operation; bit 0 = accepted write, bit 1 = accepted pop.
  typedef enum logic [1:0] {
    OpIdle  = 2'b00,
    OpWrite = 2'b01,
    OpPop   = 2'b10,
    OpBoth  = 2'b11
  } buf_op_e;

  function automatic buf_op_e buf_op(input logic wr, input logic pop);
    return buf_op_e'({pop, wr});
  endfunction

endpackage

// File: rtl/proc_out_buffer_if.sv
// Handshake and status bundle between proc, the output byte buffer and its reader.
// master: producer/reader side; slave: the buffer itself.
interface proc_out_buffer_if
  import proc_buf_pkg::*;
#(
  parameter int unsigned DATA_W = PROC_BYTE_W,
  parameter int unsigned ADDR_W = PROC_BUF_AW
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              ovf_clr;

  modport master (
    output in_valid, in_data, rd_en, ovf_clr,
    input  in_ready, rd_data, rd_valid, count, empty, full, ovf
  );

  modport slave (
    input  in_valid, in_data, rd_en, ovf_clr,
    output in_ready, rd_data, rd_valid, count, empty, full, ovf
  );

endinterface

// File: rtl/proc_byte_ram.sv
// DEPTH x DATA_W simple dual-port RAM: one write port, one registered read port.
// Read-before-write on an address collision; data is never reset.
module proc_byte_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and registered read; the read sees the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/proc_out_buffer.sv
// Circular byte store capturing proc output bytes, drained in order under rd_en.
// Optional build macro PROC_OUT_BUF_OVERWRITE_EN: when defined, writes into a full store
// overwrite the oldest byte instead of being dropped.
module proc_out_buffer
  import proc_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = PROC_BUF_DEPTH,
  parameter int unsigned ADDR_W = PROC_BUF_AW,
  parameter int unsigned DATA_W = PROC_BYTE_W
) (
  input logic               clk_i,
  input logic               rst_i,
  proc_out_buffer_if.slave  bus_io
);

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] ram_rdata;

  logic    full, empty, in_ready;
  logic    wr_acc, pop_acc, drop_oldest, ovf_set;
  buf_op_e op;

  // Flags come from the registered count only; pointers alone cannot tell full from empty.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

`ifdef PROC_OUT_BUF_OVERWRITE_EN
  assign in_ready    = 1'b1;
  // A write into a full store with no pop pushes the oldest byte out.
  assign drop_oldest = wr_acc & full & ~pop_acc;
`else
  assign in_ready    = ~full;
  assign drop_oldest = 1'b0;
`endif

  assign wr_acc  = bus_io.in_valid & in_ready;
  assign pop_acc = bus_io.rd_en & ~empty;
  assign ovf_set = bus_io.in_valid & full;
  assign op      = buf_op(wr_acc, pop_acc);

  // Pointer and occupancy next-state from the accepted operation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      OpWrite: begin
        wr_ptr_d = wr_ptr_q + PtrOne;
        if (drop_oldest) begin
          rd_ptr_d = rd_ptr_q + PtrOne;
        end else begin
          count_d = count_q + CntOne;
        end
      end
      OpPop: begin
        rd_ptr_d = rd_ptr_q + PtrOne;
        count_d  = count_q - CntOne;
      end
      OpBoth: begin
        wr_ptr_d = wr_ptr_q + PtrOne;
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      default: begin
      end
    endcase
  end

  // Read strobe, held read data and sticky overflow next-state.
  always_comb begin
    rd_valid_d = pop_acc;
    hold_d     = rd_valid_q ? ram_rdata : hold_q;
    ovf_d      = ovf_set | (ovf_q & ~bus_io.ovf_clr);
  end

  // Control state register; reset wins over any in-flight write or pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      hold_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      hold_q     <= hold_d;
    end
  end

  proc_byte_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_acc & ~rst_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus_io.in_data),
    .re_i    (pop_acc & ~rst_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // The RAM output register is only meaningful in the pop-response cycle; otherwise
  // present the last popped byte (zero after reset).
  assign bus_io.rd_data  = rd_valid_q ? ram_rdata : hold_q;
  assign bus_io.rd_valid = rd_valid_q;
  assign bus_io.in_ready = in_ready;
  assign bus_io.count    = count_q;
  assign bus_io.empty    = empty;
  assign bus_io.full     = full;
  assign bus_io.ovf      = ovf_q;

endmodule

// File: tb/tb_proc_out_buffer.sv
// Self-checking bench for proc_out_buffer: queue-based reference model plus a
// scoreboard of expected popped bytes, checked by a negedge monitor.
module tb_proc_out_buffer;
  import proc_buf_pkg::*;

  localparam int Depth = 256;
`ifdef PROC_OUT_BUF_OVERWRITE_EN
  localparam bit Ovw = 1'b1;
`else
  localparam bit Ovw = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  proc_out_buffer_if bus ();

  proc_out_buffer #(
    .DEPTH  (256),
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  bit    checking = 1'b0;

  byte_t mq[$];     // bytes held by the buffer, oldest first
  byte_t exp_q[$];  // scoreboard: bytes the reader should see next
  bit    m_ovf;
  bit    m_rv;
  byte_t m_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference model across one clock edge using the inputs held at that edge.
  task automatic model_update();
    int    sz;
    bit    pop_ok, wr_ok;
    byte_t b;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_rv   = 1'b0;
      m_last = '0;
      return;
    end
    sz     = mq.size();
    pop_ok = bus.rd_en && (sz > 0);
    wr_ok  = bus.in_valid && ((sz < Depth) || Ovw);
    m_rv   = 1'b0;
    if (pop_ok) begin
      b = mq.pop_front();
      exp_q.push_back(b);
      m_last = b;
      m_rv   = 1'b1;
    end
    if (wr_ok) begin
      if (mq.size() == Depth) b = mq.pop_front();
      mq.push_back(bus.in_data);
    end
    if (bus.in_valid && (sz == Depth)) m_ovf = 1'b1;
    else if (bus.ovf_clr)               m_ovf = 1'b0;
  endtask

  task automatic step(input bit v, input byte_t d, input bit r, input bit clr, input bit rs);
    rst          = rs;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_en    = r;
    bus.ovf_clr  = clr;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic push(input byte_t d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare status every cycle; pop the scoreboard on every rd_valid.
  always @(negedge clk) begin
    if (checking) begin
      chk("count", int'(bus.count), mq.size());
      chk("empty", int'(bus.empty), int'(mq.size() == 0));
      chk("full", int'(bus.full), int'(mq.size() == Depth));
      chk("in_ready", int'(bus.in_ready), int'(Ovw || (mq.size() < Depth)));
      chk("ovf", int'(bus.ovf), int'(m_ovf));
      chk("rd_valid", int'(bus.rd_valid), int'(m_rv));
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          chk("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
        end
      end else begin
        chk("rd_hold", int'(bus.rd_data), int'(m_last));
      end
    end
  end

  initial begin
    bit mode;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rd_en    = 1'b0;
    bus.ovf_clr  = 1'b0;
    do_reset();
    checking = 1'b1;

    // In-order drain of a short burst.
    push(8'h23); push(8'h23); push(8'hC3); push(8'hC3);
    repeat (4) pop();
    idle();

    // Fill to full, drop one byte, clear ovf, drain.
    do_reset();
    for (int i = 0; i < 256; i++) push(byte_t'(i));
    push(8'h61);
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (256) pop();
    idle();

    // Pointer wrap past 255 -> 0.
    do_reset();
    for (int i = 0; i < 200; i++) push(byte_t'(i * 3));
    repeat (200) pop();
    for (int i = 0; i < 100; i++) push(byte_t'(8'hA0 + i));
    repeat (100) pop();
    idle();

    // Simultaneous write+pop at count=5, then at count=0.
    do_reset();
    for (int i = 0; i < 5; i++) push(byte_t'(8'h10 + i));
    for (int i = 0; i < 10; i++) step(1'b1, byte_t'(8'h50 + i), 1'b1, 1'b0, 1'b0);
    repeat (5) pop();
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    pop();
    idle();

    // Reset while a pop is in flight at count=37.
    do_reset();
    for (int i = 0; i < 37; i++) push(byte_t'(8'h80 + i));
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle();

`ifdef PROC_OUT_BUF_OVERWRITE_EN
    // Overwrite while full: oldest byte lost, new byte lands last.
    do_reset();
    for (int i = 0; i < 256; i++) push(byte_t'(i));
    push(8'hEE);
    step(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0);
    repeat (256) pop();
    idle();
`endif

    // Randomised traffic alternating fill-biased and drain-biased phases.
    do_reset();
    mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end else begin
        step(mode ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3),
             byte_t'($urandom),
             mode ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 49) == 0),
             1'b0);
      end
    end
    repeat (300) pop();
    idle();
    idle();

    checking = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
